// File: rtl/vrf_writeback_arbiter.sv
// vrf_writeback_arbiter: round-robin arbiter that shares the single vector register file
// write port among NUM_REQ writeback sources, with one registered output stage.
// Optional outstanding-write scoreboard is built when VWB_SCOREBOARD_EN is defined;
// otherwise o_busy and o_rsv_err are tied to zero and no scoreboard state exists.
module vrf_writeback_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LANES   = 4,
  parameter int unsigned LANE_W  = 32
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]         i_req_addr,
  input  logic [NUM_REQ*LANES*LANE_W-1:0]   i_req_data,
  input  logic [NUM_REQ*LANES-1:0]          i_req_mask,
  output logic [ADDR_W-1:0]                 o_vrf_write_addr,
  output logic [LANES*LANE_W-1:0]           o_vrf_write_data,
  output logic [LANES-1:0]                  o_vrf_we,
  input  logic                              i_rsv_valid,
  input  logic [ADDR_W-1:0]                 i_rsv_addr,
  output logic [2**ADDR_W-1:0]              o_busy,
  output logic                              o_rsv_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned PAD   = 2**PTR_W;

  logic [PTR_W-1:0]        r_ptr;
  logic [ADDR_W-1:0]       r_addr;
  logic [LANES*LANE_W-1:0] r_data;
  logic [LANES-1:0]        r_we;

  logic [PAD-1:0]          w_valid_pad;
  logic [PTR_W:0]          w_cand;
  logic                    w_gnt_any;
  logic [PTR_W-1:0]        w_gnt_idx;
  logic [NUM_REQ-1:0]      w_gnt_oh;
  logic [PTR_W:0]          w_ptr_inc;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [LANES*LANE_W-1:0] w_sel_data;
  logic [LANES-1:0]        w_sel_mask;

  // Padding lets the wrapped candidate index a power-of-two vector without range issues.
  assign w_valid_pad = PAD'(i_req_valid);

  // Round-robin search starting at r_ptr, first valid requester wins; no grant while in reset.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_cand = {1'b0, r_ptr} + (PTR_W+1)'(off);
      if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_gnt_any && w_valid_pad[w_cand[PTR_W-1:0]]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand[PTR_W-1:0];
      end
    end
    w_gnt_any = w_gnt_any & i_rst_n;
  end

  // One-hot grant and pointer successor (grantee + 1, wrapping to 0).
  always_comb begin
    w_gnt_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = w_gnt_any && (w_gnt_idx == PTR_W'(i));
    end
    w_ptr_inc = {1'b0, w_gnt_idx} + (PTR_W+1)'(1);
    w_ptr_nxt = (w_ptr_inc == (PTR_W+1)'(NUM_REQ)) ? '0 : w_ptr_inc[PTR_W-1:0];
  end

  assign o_req_ready = w_gnt_oh;

  // Select the grantee's address, write vector and lane mask.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = i_req_data[i*LANES*LANE_W +: LANES*LANE_W];
        w_sel_mask = i_req_mask[i*LANES +: LANES];
      end
    end
  end

  // Output stage: one-cycle write pulse per grant; address/data hold while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_we   <= '0;
    end else if (w_gnt_any) begin
      r_ptr  <= w_ptr_nxt;
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
      r_we   <= w_sel_mask;
    end else begin
      r_we   <= '0;
    end
  end

  assign o_vrf_write_addr = r_addr;
  assign o_vrf_write_data = r_data;
  assign o_vrf_we         = r_we;

`ifdef VWB_SCOREBOARD_EN
  logic [2**ADDR_W-1:0] r_busy;
  logic [2**ADDR_W-1:0] w_busy_nxt;
  logic                 r_rsv_err;
  logic                 w_rsv_err_nxt;

  // Writeback (even mask 0) clears its register; a new reservation is applied last so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_gnt_any) begin
      w_busy_nxt[w_sel_addr] = 1'b0;
    end
    w_rsv_err_nxt = i_rsv_valid && r_busy[i_rsv_addr] &&
                    !(w_gnt_any && (w_sel_addr == i_rsv_addr));
    if (i_rsv_valid) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end
  end

  // Scoreboard state and single-cycle double-reservation flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_rsv_err <= w_rsv_err_nxt;
    end
  end

  assign o_busy    = r_busy;
  assign o_rsv_err = r_rsv_err;
`else
  logic w_unused_rsv;

  assign w_unused_rsv = ^{i_rsv_valid, i_rsv_addr};
  assign o_busy       = '0;
  assign o_rsv_err    = 1'b0;
`endif

endmodule
